sha_trailer_strip_check: RTL

- Receive-side counterpart of the "replace last beat with SHA-256 digest" transmit path.
- Accepts a host/network AXI4-Stream packet whose final beat carries a 256-bit SHA-256 digest. Strips that trailer beat and forwards the payload with tlast moved onto the last payload beat.
- Captures the received digest and compares it against the digest returned by an external sha256 core that hashes the forwarded payload.
- Emits one status word per packet. Sits between the input FIFO and the inputFIFODuplicate/sha256 pair.

---
 rtl/sha_trailer_strip_check_pkg.sv | 27 ++
 rtl/sha_trailer_strip_check_axis_lookahead_hold.sv | 67 ++++++
 rtl/sha_trailer_strip_check.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/sha_trailer_strip_check_pkg.sv
`default_nettype none
// ============================================================================
// sha_trailer_strip_check_pkg : shared constants and types for the trailer
//                               strip / digest check block
// Revision: 1.0
// ============================================================================
package sha_trailer_strip_check_pkg;

  localparam int SHA_DIGEST_BITS = 256;
  localparam int DIGEST_LSB      = 0;

  localparam logic [1:0] ST_EMPTY    = 2'd0;
  localparam logic [1:0] ST_HOLD     = 2'd1;
  localparam logic [1:0] ST_WAIT_CHK = 2'd2;
  localparam logic [1:0] ST_REPORT   = 2'd3;

  typedef logic [1:0] state_t;

  // Beat count and id widths follow the top-level parameters, so they live
  // beside this struct rather than inside it.
  typedef struct packed {
    logic match;
    logic short_pkt;
  } sts_flags_t;

endpackage
`default_nettype wire

// File: rtl/sha_trailer_strip_check_axis_lookahead_hold.sv
`default_nettype none
// ============================================================================
// sha_trailer_strip_check_axis_lookahead_hold : one-beat hold register used to
//                                               re-time tlast onto the prior beat
// Revision: 1.0
// ============================================================================
module sha_trailer_strip_check_axis_lookahead_hold
  import sha_trailer_strip_check_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH   = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic                    clear,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [DATA_WIDTH/8-1:0] in_keep,
  input  logic [ID_WIDTH-1:0]     in_id,
  output logic                    hold_valid,
  output logic [DATA_WIDTH-1:0]   hold_data,
  output logic [DATA_WIDTH/8-1:0] hold_keep,
  output logic [ID_WIDTH-1:0]     hold_id
);

  logic                    valid_q, valid_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [DATA_WIDTH/8-1:0] keep_q, keep_d;
  logic [ID_WIDTH-1:0]     id_q, id_d;

  // A load always wins over a clear: a new beat replaces the old one.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    keep_d  = keep_q;
    id_d    = id_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data;
      keep_d  = in_keep;
      id_d    = in_id;
    end else if (clear) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      id_q    <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      id_q    <= id_d;
    end
  end

  assign hold_valid = valid_q;
  assign hold_data  = data_q;
  assign hold_keep  = keep_q;
  assign hold_id    = id_q;

endmodule
`default_nettype wire

// File: rtl/sha_trailer_strip_check.sv
`default_nettype none
// ============================================================================
// sha_trailer_strip_check : strips the SHA-256 trailer beat from a packet and
//                           checks it against the externally computed digest
// Revision: 1.0
// ============================================================================
module sha_trailer_strip_check
  import sha_trailer_strip_check_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH   = 6,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [ID_WIDTH-1:0]     s_axis_tid,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [ID_WIDTH-1:0]     m_axis_tid,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  input  logic [DATA_WIDTH-1:0]   chk_tdata,
  input  logic                    chk_tvalid,
  output logic                    chk_tready,
  output logic                    sts_match,
  output logic                    sts_short,
  output logic [CNT_WIDTH-1:0]    sts_beats,
  output logic [ID_WIDTH-1:0]     sts_id,
  output logic                    sts_valid,
  input  logic                    sts_ready
);

  state_t                     state_q, state_d;
  logic [SHA_DIGEST_BITS-1:0] digest_q, digest_d;
  logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
  logic [ID_WIDTH-1:0]        id_q, id_d;
  sts_flags_t                 flags_q, flags_d;

  logic                    hold_load, hold_clear, hold_valid;
  logic [DATA_WIDTH-1:0]   hold_data;
  logic [DATA_WIDTH/8-1:0] hold_keep;
  logic [ID_WIDTH-1:0]     hold_id;

  logic s_rdy, m_vld, chk_rdy, sts_vld;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic unused_chk;

  assign unused_chk = ^chk_tdata;
  assign cnt_inc    = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q
                    : cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  sha_trailer_strip_check_axis_lookahead_hold #(
    .DATA_WIDTH (DATA_WIDTH),
    .ID_WIDTH   (ID_WIDTH)
  ) u_hold (
    .clk        (aclk),
    .rst_n      (areset),
    .load       (hold_load),
    .clear      (hold_clear),
    .in_data    (s_axis_tdata),
    .in_keep    (s_axis_tkeep),
    .in_id      (s_axis_tid),
    .hold_valid (hold_valid),
    .hold_data  (hold_data),
    .hold_keep  (hold_keep),
    .hold_id    (hold_id)
  );

  always_comb begin
    state_d    = state_q;
    digest_d   = digest_q;
    cnt_d      = cnt_q;
    id_d       = id_q;
    flags_d    = flags_q;
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    s_rdy      = 1'b0;
    m_vld      = 1'b0;
    chk_rdy    = 1'b0;
    sts_vld    = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        s_rdy = 1'b1;
        if (s_axis_tvalid) begin
          if (!s_axis_tlast) begin
            hold_load = 1'b1;
            state_d   = ST_HOLD;
          end else begin
            // Trailer with no payload: nothing was hashed, so skip the chk wait.
            digest_d          = s_axis_tdata[DIGEST_LSB +: SHA_DIGEST_BITS];
            id_d              = s_axis_tid;
            flags_d.match     = 1'b0;
            flags_d.short_pkt = 1'b1;
            cnt_d             = '0;
            state_d           = ST_REPORT;
          end
        end
      end
      ST_HOLD: begin
        // The held beat goes out only alongside its successor, which decides tlast.
        m_vld = s_axis_tvalid & hold_valid;
        s_rdy = m_axis_tready;
        if (s_axis_tvalid && m_axis_tready) begin
          cnt_d = cnt_inc;
          if (!s_axis_tlast) begin
            hold_load = 1'b1;
          end else begin
            digest_d   = s_axis_tdata[DIGEST_LSB +: SHA_DIGEST_BITS];
            id_d       = s_axis_tid;
            hold_clear = 1'b1;
            state_d    = ST_WAIT_CHK;
          end
        end
      end
      ST_WAIT_CHK: begin
        chk_rdy = 1'b1;
        if (chk_tvalid) begin
          flags_d.match     = (chk_tdata[DIGEST_LSB +: SHA_DIGEST_BITS] == digest_q);
          flags_d.short_pkt = 1'b0;
          state_d           = ST_REPORT;
        end
      end
      ST_REPORT: begin
        sts_vld = 1'b1;
        if (sts_ready) begin
          cnt_d   = '0;
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      state_q  <= ST_EMPTY;
      digest_q <= '0;
      cnt_q    <= '0;
      id_q     <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      digest_q <= digest_d;
      cnt_q    <= cnt_d;
      id_q     <= id_d;
      flags_q  <= flags_d;
    end
  end

  // Handshake outputs are forced low for as long as reset is asserted.
  assign s_axis_tready = areset & s_rdy;
  assign m_axis_tvalid = areset & m_vld;
  assign chk_tready    = areset & chk_rdy;
  assign sts_valid     = areset & sts_vld;

  assign m_axis_tdata  = hold_data;
  assign m_axis_tkeep  = hold_keep;
  assign m_axis_tid    = hold_id;
  assign m_axis_tlast  = s_axis_tlast;

  assign sts_match     = flags_q.match;
  assign sts_short     = flags_q.short_pkt;
  assign sts_beats     = cnt_q;
  assign sts_id        = id_q;

endmodule
`default_nettype wire
